// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with valid/ready intake.
// Frame: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY_EN != 0);
  localparam logic PAR_INV = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic par, par_n;
  logic tx_q, tx_n;
  logic done_q, done_n;
  logic bit_end;

  assign bit_end  = (cnt == CNT_MAX);
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign tx       = tx_q;
  assign done     = done_q;

  // State and datapath registers; line idles high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      par    <= 1'b0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      par    <= par_n;
      tx_q   <= tx_n;
      done_q <= done_n;
    end
  end

  // Next-state and next line level; tx changes only on bit boundaries.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    tx_n    = tx_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        idx_n = '0;
        if (tx_valid) begin
          state_n = START;
          sh_n    = tx_data;
          par_n   = (^tx_data) ^ PAR_INV;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          tx_n    = sh[0];
          sh_n    = sh >> 1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == DATA_LAST) begin
            idx_n = '0;
            if (HAS_PAR) begin
              state_n = PARITY;
              tx_n    = par;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx + 4'd1;
            tx_n  = sh[0];
            sh_n  = sh >> 1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == STOP_LAST) begin
            idx_n   = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
